// File: rtl/uart_pkg.sv
// Shared UART constants and the frame state type, imported by both the TX and RX sides.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int   UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int uart_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample phase counter: advances on tick16 and flags the tick at which phase hits COMPARE.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int COMPARE    = OVERSAMPLE - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic tick16,
  input  logic clear,
  output logic bit_end
);

  localparam int              PW   = uart_cnt_width(OVERSAMPLE);
  localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] CMP  = PW'(COMPARE);

  logic [PW-1:0] phase_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_reg <= '0;
    end else if (clear) begin
      phase_reg <= '0;
    end else if (tick16) begin
      phase_reg <= (phase_reg == LAST) ? '0 : phase_reg + PW'(1);
    end
  end

  assign bit_end = tick16 && (phase_reg == CMP);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a word on send/ready and shifts out start, data (LSB first) and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick16,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 done,
  output logic                 tx
);

  localparam int            BW        = uart_cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 bit_end;
  logic                 timer_clear;

  // Holding the phase at zero while idle makes every bit, start included, last a full tick count.
  assign timer_clear = (state_reg == IDLE);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE),
    .COMPARE   (OVERSAMPLE - 1)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .tick16 (tick16),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (send) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && (bit_cnt_reg == LAST_BIT)) state_next = STOP;
      STOP:  if (bit_end && (stop_cnt_reg == LAST_STOP)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state_reg == IDLE);
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (send) begin
          shift_next    = data;
          tx_next       = ~UART_IDLE_LEVEL;
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          tx_next      = shift_reg[0];
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_BIT) begin
            tx_next       = UART_IDLE_LEVEL;
            stop_cnt_next = 1'b0;
          end else begin
            tx_next      = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == LAST_STOP) begin
            done_next = 1'b1;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= UART_IDLE_LEVEL;
      done_reg     <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  assign tx   = tx_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus hand-written back-to-back, reset and stall sequences.
module tb_uart_tx_frame;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick16;
  logic       send, send2;
  logic [7:0] data;
  logic [6:0] data2;
  logic       ready, done, tx;
  logic       ready2, done2, tx2;

  int checks = 0;
  int fails = 0;
  int tick_period = 1;
  int tick_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    bit         use2;
    logic [7:0] data;
    int         period;
    logic [9:0] bits;
    int         len_min;
    int         len_max;
    int         inject;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  uart_tx_frame dut (
    .clock (clock),
    .reset (reset),
    .tick16(tick16),
    .send  (send),
    .data  (data),
    .ready (ready),
    .done  (done),
    .tx    (tx)
  );

  uart_tx_frame #(
    .DATA_BITS (7),
    .OVERSAMPLE(16),
    .STOP_BITS (2)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .tick16(tick16),
    .send  (send2),
    .data  (data2),
    .ready (ready2),
    .done  (done2),
    .tx    (tx2)
  );

  initial begin
    tick16 = 1'b0;
    forever begin
      @(negedge clock);
      if (tick_period <= 0) begin
        tick16   = 1'b0;
        tick_cnt = 0;
      end else if (tick_cnt >= tick_period - 1) begin
        tick16   = 1'b1;
        tick_cnt = 0;
      end else begin
        tick16   = 1'b0;
        tick_cnt = tick_cnt + 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Change tick spacing midway between edges so the generator picks it up deterministically.
  task automatic set_ticks(input int p);
    @(posedge clock);
    #2;
    tick_period = p;
    tick_cnt    = 0;
  endtask

  task automatic wait_ready(input bit use2);
    int k;
    k = 0;
    while (!(use2 ? ready2 : ready) && k < 2000) begin
      @(negedge clock);
      k = k + 1;
    end
    chk("ready_wait", 32'(use2 ? ready2 : ready), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    logic hist [0:4095];
    int   n;
    int   ready_low;
    int   idx;
    bit   seen;
    if (tick_period != v.period) set_ticks(v.period);
    wait_ready(v.use2);
    @(negedge clock);
    if (v.use2) begin
      data2 = v.data[6:0];
      send2 = 1'b1;
    end else begin
      data = v.data;
      send = 1'b1;
    end
    @(negedge clock);
    send      = 1'b0;
    send2     = 1'b0;
    n         = 0;
    ready_low = 0;
    seen      = 1'b0;
    while (!seen && n < 4000) begin
      hist[n] = v.use2 ? tx2 : tx;
      if (v.use2 ? done2 : done) begin
        seen = 1'b1;
      end else begin
        if (!(v.use2 ? ready2 : ready)) ready_low = ready_low + 1;
        if (v.inject != 0 && n == v.inject) begin
          data = 8'h3C;
          send = 1'b1;
        end else begin
          send = 1'b0;
        end
        @(negedge clock);
        n = n + 1;
      end
    end
    send = 1'b0;
    chk($sformatf("frame_%0h_done_seen", v.data), 32'(seen), 32'd1);
    if (seen) begin
      chk_range($sformatf("frame_%0h_len", v.data), n, v.len_min, v.len_max);
      chk($sformatf("frame_%0h_ready_low", v.data), 32'(ready_low), 32'(n));
      chk($sformatf("frame_%0h_ready_at_done", v.data), 32'(v.use2 ? ready2 : ready), 32'd1);
      for (int j = 0; j < 10; j++) begin
        idx = n - (9 - j) * 16 * v.period - 8 * v.period;
        chk($sformatf("frame_%0h_bit%0d", v.data, j), 32'(hist[idx]), 32'(v.bits[j]));
      end
      @(negedge clock);
      chk($sformatf("frame_%0h_done_pulse_end", v.data), 32'(v.use2 ? done2 : done), 32'd0);
    end
  endtask

  initial begin
    int   n;
    int   d0;
    vec_t v81;

    vecs[0] = '{1'b0, 8'hA5, 1, 10'b1101001010, 160, 160, 0};
    vecs[1] = '{1'b0, 8'h5A, 3, 10'b1010110100, 478, 480, 0};
    vecs[2] = '{1'b0, 8'h81, 4, 10'b1100000010, 637, 640, 0};
    vecs[3] = '{1'b0, 8'hA5, 1, 10'b1101001010, 160, 160, 50};
    vecs[4] = '{1'b1, 8'h55, 1, 10'b1110101010, 160, 160, 0};
    vecs[5] = '{1'b1, 8'h0F, 2, 10'b1100011110, 319, 320, 0};
    v81     = '{1'b0, 8'h81, 1, 10'b1100000010, 160, 160, 0};

    reset = 1'b1;
    send  = 1'b0;
    send2 = 1'b0;
    data  = 8'h00;
    data2 = 7'h00;
    repeat (3) @(negedge clock);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_tx2", 32'(tx2), 32'd1);
    chk("reset_ready2", 32'(ready2), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
    end

    // The ignored 3C request must not start another frame.
    d0 = done_cnt;
    repeat (200) @(negedge clock);
    chk("no_queued_frame_done", 32'(done_cnt), 32'(d0));
    chk("no_queued_frame_tx", 32'(tx), 32'd1);

    // Back-to-back 00 then FF with send held high, ticks every 4 clocks.
    set_ticks(4);
    wait_ready(1'b0);
    d0 = done_cnt;
    @(negedge clock);
    data = 8'h00;
    send = 1'b1;
    @(negedge clock);
    chk("b2b_accept1", 32'(ready), 32'd0);
    data = 8'hFF;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clock);
      n = n + 1;
      if (n == 300) chk("b2b_data0_low", 32'(tx), 32'd0);
    end
    chk_range("b2b_len1", n, 637, 640);
    chk("b2b_stop_at_done", 32'(tx), 32'd1);
    @(negedge clock);
    chk("b2b_restart_ready", 32'(ready), 32'd0);
    chk("b2b_restart_tx", 32'(tx), 32'd0);
    send = 1'b0;
    n = 1;
    while (!done && n < 3000) begin
      @(negedge clock);
      n = n + 1;
      if (n == 300) chk("b2b_dataff_high", 32'(tx), 32'd1);
    end
    chk("b2b_period", 32'(n), 32'd640);
    @(negedge clock);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset in the middle of data bit 4 of an all-zero byte.
    set_ticks(1);
    wait_ready(1'b0);
    d0 = done_cnt;
    @(negedge clock);
    data = 8'h00;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    repeat (88) @(negedge clock);
    chk("rst_pre_tx", 32'(tx), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx), 32'd1);
    chk("rst_async_ready", 32'(ready), 32'd1);
    chk("rst_async_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    run_frame(v81);

    // Ticks stopped right after accept: the start bit must freeze.
    set_ticks(0);
    wait_ready(1'b0);
    @(negedge clock);
    data = 8'hA5;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    repeat (50) @(negedge clock);
    chk("stall_tx", 32'(tx), 32'd0);
    chk("stall_ready", 32'(ready), 32'd0);
    chk("stall_done", 32'(done), 32'd0);
    set_ticks(1);
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clock);
      n = n + 1;
    end
    // One negedge passes before the first tick is driven, then 160 ticks.
    chk("stall_resume_len", 32'(n), 32'd161);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
